// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the 2-bit direction counter encoding, the BTB entry layout and the
// counter values used on reset and on allocation. Entry field widths follow
// the package geometry. The top-level parameters default to these values
// and must match them.
package bp_pkg;

    localparam int BP_ADDR_WIDTH = 32;
    localparam int BP_INDEX_BITS = 6;
    localparam int BP_TAG_BITS   = BP_ADDR_WIDTH - BP_INDEX_BITS - 2;
    localparam int BP_ENTRIES    = 1 << BP_INDEX_BITS;

    // Direction counter: upper bit is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_BITS-1:0]   tag;
        logic [BP_ADDR_WIDTH-1:0] target;
        bp_ctr_t                  ctr;
    } bp_entry_t;

    // Entries start weakly not-taken after reset. A fresh allocation is
    // always caused by a taken branch, so it starts weakly taken.
    localparam bp_ctr_t BP_CTR_INIT  = WNT;
    localparam bp_ctr_t BP_CTR_ALLOC = WT;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side resolve bundle for the branch predictor.
// Latency: n/a (wires only).
// Backpressure: none. The execute side qualifies updates with validE_i.
//
// The master modport belongs to the pipeline and the slave modport to the
// predictor.
//   fetch   : pcF_i -> predTakenF_o, predTargetF_o
//   execute : validE_i, branchE_i, branchCondE_i, pcE_i, targetE_i,
//             predTakenE_i, predTargetE_i -> mispredictE_o, redirectPcE_o
//   stats   : mispredictCount_o
interface branch_predictor_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pcF_i;
    logic                  predTakenF_o;
    logic [ADDR_WIDTH-1:0] predTargetF_o;

    logic                  validE_i;
    logic                  branchE_i;
    logic                  branchCondE_i;
    logic [ADDR_WIDTH-1:0] pcE_i;
    logic [ADDR_WIDTH-1:0] targetE_i;
    logic                  predTakenE_i;
    logic [ADDR_WIDTH-1:0] predTargetE_i;
    logic                  mispredictE_o;
    logic [ADDR_WIDTH-1:0] redirectPcE_o;

    logic [31:0]           mispredictCount_o;

    modport master (
        output pcF_i,
        input  predTakenF_o, predTargetF_o,
        output validE_i, branchE_i, branchCondE_i, pcE_i, targetE_i,
        output predTakenE_i, predTargetE_i,
        input  mispredictE_o, redirectPcE_o,
        input  mispredictCount_o
    );

    modport slave (
        input  pcF_i,
        output predTakenF_o, predTargetF_o,
        input  validE_i, branchE_i, branchCondE_i, pcE_i, targetE_i,
        input  predTakenE_i, predTargetE_i,
        output mispredictE_o, redirectPcE_o,
        output mispredictCount_o
    );

endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: ctr_i (current counter), taken_i (resolved outcome), ctr_o (next counter).
// Taken moves the counter toward ST, not-taken moves it toward SNT, and it
// holds at either end.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            case (ctr_i)
                SNT:     ctr_o = WNT;
                WNT:     ctr_o = WT;
                WT:      ctr_o = ST;
                default: ctr_o = ST;
            endcase
        end else begin
            case (ctr_i)
                ST:      ctr_o = WT;
                WT:      ctr_o = WNT;
                WNT:     ctr_o = SNT;
                default: ctr_o = SNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: fetch prediction, execute resolve/train, mispredict counter.
// Latency: prediction and resolve are combinational (zero cycles); table update is visible one cycle later.
// Backpressure: none. The table trains only when validE_i && branchE_i, so stalls and bubbles are ignored.
//
// Ports: clk, rst (synchronous, active-high), bp (branch_predictor_if.slave).
// The fetch read does not bypass a same-cycle execute write. The read sees
// the pre-write entry even at the same index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    bp_entry_t table_q [ENTRIES];
    logic [31:0] mispredict_cnt_q;

    // ---------------- fetch-side prediction ----------------
    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0]   tag_f;
    bp_entry_t             rd_f;
    logic                  hit_f;
    logic                  pred_taken_f;
    logic [ADDR_WIDTH-1:0] pc_plus4_f;

    assign idx_f        = bp.pcF_i[INDEX_BITS+1:2];
    assign tag_f        = bp.pcF_i[ADDR_WIDTH-1:INDEX_BITS+2];
    assign rd_f         = table_q[idx_f];
    assign hit_f        = rd_f.valid && (rd_f.tag == tag_f);
    assign pred_taken_f = hit_f && rd_f.ctr[1];
    // The sum is truncated to ADDR_WIDTH, so PC+4 wraps at the top of the address space.
    assign pc_plus4_f   = bp.pcF_i + ADDR_WIDTH'(4);

    assign bp.predTakenF_o  = pred_taken_f;
    assign bp.predTargetF_o = pred_taken_f ? rd_f.target : pc_plus4_f;

    // ---------------- execute-side resolve ----------------
    logic                  live_e;
    logic                  dir_wrong_e;
    logic                  tgt_wrong_e;
    logic                  mispredict_e;
    logic [ADDR_WIDTH-1:0] pc_plus4_e;

    assign live_e       = bp.validE_i && bp.branchE_i;
    assign dir_wrong_e  = bp.branchCondE_i != bp.predTakenE_i;
    // A target mismatch matters only when both predicted and actual are
    // taken. On a not-taken branch the predicted target was pc+4 anyway.
    assign tgt_wrong_e  = bp.branchCondE_i && bp.predTakenE_i &&
                          (bp.predTargetE_i != bp.targetE_i);
    assign mispredict_e = live_e && (dir_wrong_e || tgt_wrong_e);
    assign pc_plus4_e   = bp.pcE_i + ADDR_WIDTH'(4);

    assign bp.mispredictE_o = mispredict_e;
    assign bp.redirectPcE_o = bp.branchCondE_i ? bp.targetE_i : pc_plus4_e;

    // ---------------- execute-side training ----------------
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_e;
    bp_entry_t             rd_e;
    logic                  hit_e;
    bp_ctr_t               ctr_nxt_e;

    assign idx_e = bp.pcE_i[INDEX_BITS+1:2];
    assign tag_e = bp.pcE_i[ADDR_WIDTH-1:INDEX_BITS+2];
    assign rd_e  = table_q[idx_e];
    assign hit_e = rd_e.valid && (rd_e.tag == tag_e);

    bp_sat_ctr u_sat_ctr (
        .ctr_i   (rd_e.ctr),
        .taken_i (bp.branchCondE_i),
        .ctr_o   (ctr_nxt_e)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset takes priority over a same-cycle update, so that update is dropped.
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_INIT};
            end
            mispredict_cnt_q <= '0;
        end else begin
            if (live_e) begin
                if (hit_e) begin
                    table_q[idx_e].ctr <= ctr_nxt_e;
                    if (bp.branchCondE_i) begin
                        table_q[idx_e].target <= bp.targetE_i;
                    end
                end else if (bp.branchCondE_i) begin
                    // Miss on a taken branch replaces whatever aliased into this slot.
                    table_q[idx_e] <= '{valid:  1'b1,
                                        tag:    tag_e,
                                        target: bp.targetE_i,
                                        ctr:    BP_CTR_ALLOC};
                end
            end
            if (mispredict_e && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign bp.mispredictCount_o = mispredict_cnt_q;

endmodule
